// File: rtl/clb_cfg_loader.sv
//------------------------------------------------------------------------------
// Module   : clb_cfg_loader
// Function : Framed, checksummed byte-stream loader that assembles LUT/select
//            configuration in shadow registers and commits it atomically.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module clb_cfg_loader #(
   parameter int         NUM_CLB   = 4,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cfg_valid,
   input  logic [7:0]           cfg_data,
   output logic                 cfg_ready,
   input  logic                 cfg_abort,
   output logic [8*NUM_CLB-1:0] lut_cfg,
   output logic [NUM_CLB-1:0]   sel_cfg,
   output logic                 cfg_busy,
   output logic                 cfg_done,
   output logic                 cfg_error,
   output logic                 cfg_loaded
);

   localparam int IDX_W = (NUM_CLB > 1) ? $clog2(NUM_CLB) : 1;
   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_CLB - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LUT  = 2'd1,
      S_CTRL = 2'd2,
      S_CHK  = 2'd3
   } state_t;

   state_t                 r_state;
   logic [IDX_W-1:0]       r_idx;
   logic [7:0]             r_chk;
   logic [8*NUM_CLB-1:0]   r_shadow_lut;
   logic [NUM_CLB-1:0]     r_shadow_sel;
   logic [8*NUM_CLB-1:0]   r_lut_cfg;
   logic [NUM_CLB-1:0]     r_sel_cfg;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_error;
   logic                   r_loaded;
   logic                   w_accept;

   // The loader never backpressures: it takes a byte every cycle out of reset.
   assign cfg_ready = reset;
   assign w_accept  = cfg_valid & reset;

   assign lut_cfg    = r_lut_cfg;
   assign sel_cfg    = r_sel_cfg;
   assign cfg_busy   = r_busy;
   assign cfg_done   = r_done;
   assign cfg_error  = r_error;
   assign cfg_loaded = r_loaded;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_chk        <= '0;
         r_shadow_lut <= '0;
         r_shadow_sel <= '0;
         r_lut_cfg    <= '0;
         r_sel_cfg    <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
         r_loaded     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         // Abort outranks any byte presented in the same cycle; idle is untouched.
         if (cfg_abort && (r_state != S_IDLE)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
         end else if (w_accept) begin
            case (r_state)
               S_IDLE: begin
                  if (cfg_data == SYNC_BYTE) begin
                     r_error <= 1'b0;
                     r_chk   <= '0;
                     r_idx   <= '0;
                     r_busy  <= 1'b1;
                     r_state <= S_LUT;
                  end
               end
               S_LUT: begin
                  for (int i = 0; i < NUM_CLB; i++) begin
                     if (r_idx == IDX_W'(i)) r_shadow_lut[8*i +: 8] <= cfg_data;
                  end
                  r_chk   <= r_chk ^ cfg_data;
                  r_state <= S_CTRL;
               end
               S_CTRL: begin
                  for (int i = 0; i < NUM_CLB; i++) begin
                     if (r_idx == IDX_W'(i)) r_shadow_sel[i] <= cfg_data[0];
                  end
                  r_chk <= r_chk ^ cfg_data;
                  if (r_idx == C_LAST_IDX) begin
                     r_state <= S_CHK;
                  end else begin
                     r_idx   <= r_idx + 1'b1;
                     r_state <= S_LUT;
                  end
               end
               S_CHK: begin
                  if (cfg_data == r_chk) begin
                     r_lut_cfg <= r_shadow_lut;
                     r_sel_cfg <= r_shadow_sel;
                     r_done    <= 1'b1;
                     r_loaded  <= 1'b1;
                  end else begin
                     r_error   <= 1'b1;
                  end
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_clb_cfg_loader.sv
//------------------------------------------------------------------------------
// Module   : tb_clb_cfg_loader
// Function : Directed self-checking bench for clb_cfg_loader (NUM_CLB 2, 1, 16).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_clb_cfg_loader;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   // NUM_CLB = 2
   logic v2 = 1'b0, a2 = 1'b0;
   logic [7:0] d2 = '0;
   logic rdy2, busy2, done2, err2, ld2;
   logic [15:0] lut2;
   logic [1:0]  sel2;

   // NUM_CLB = 1
   logic v1 = 1'b0, a1 = 1'b0;
   logic [7:0] d1 = '0;
   logic rdy1, busy1, done1, err1, ld1;
   logic [7:0] lut1;
   logic [0:0] sel1;

   // NUM_CLB = 16
   logic v16 = 1'b0, a16 = 1'b0;
   logic [7:0] d16 = '0;
   logic rdy16, busy16, done16, err16, ld16;
   logic [127:0] lut16;
   logic [15:0]  sel16;

   clb_cfg_loader #(.NUM_CLB(2), .SYNC_BYTE(8'hA5)) u_dut2 (
      .clk(clk), .reset(reset), .cfg_valid(v2), .cfg_data(d2), .cfg_ready(rdy2),
      .cfg_abort(a2), .lut_cfg(lut2), .sel_cfg(sel2), .cfg_busy(busy2),
      .cfg_done(done2), .cfg_error(err2), .cfg_loaded(ld2));

   clb_cfg_loader #(.NUM_CLB(1), .SYNC_BYTE(8'hA5)) u_dut1 (
      .clk(clk), .reset(reset), .cfg_valid(v1), .cfg_data(d1), .cfg_ready(rdy1),
      .cfg_abort(a1), .lut_cfg(lut1), .sel_cfg(sel1), .cfg_busy(busy1),
      .cfg_done(done1), .cfg_error(err1), .cfg_loaded(ld1));

   clb_cfg_loader #(.NUM_CLB(16), .SYNC_BYTE(8'hA5)) u_dut16 (
      .clk(clk), .reset(reset), .cfg_valid(v16), .cfg_data(d16), .cfg_ready(rdy16),
      .cfg_abort(a16), .lut_cfg(lut16), .sel_cfg(sel16), .cfg_busy(busy16),
      .cfg_done(done16), .cfg_error(err16), .cfg_loaded(ld16));

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one byte to the selected DUT for a single edge; returns at edge+1.
   task automatic send(input int which, input logic [7:0] b);
      case (which)
         1:       begin v1  = 1'b1; d1  = b; end
         16:      begin v16 = 1'b1; d16 = b; end
         default: begin v2  = 1'b1; d2  = b; end
      endcase
      @(posedge clk); #1;
      v1 = 1'b0; v2 = 1'b0; v16 = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   logic [7:0]   gf [6];
   logic [7:0]   lb [16];
   logic [7:0]   cb [16];
   logic [7:0]   sum;
   logic [127:0] exp_lut;
   logic [15:0]  exp_sel;

   initial begin
      gf[0] = 8'hA5; gf[1] = 8'h33; gf[2] = 8'h00;
      gf[3] = 8'h96; gf[4] = 8'h01; gf[5] = 8'hA4;

      // Reset state
      #12;
      chk("rst_lut",    128'(lut2), 128'(0));
      chk("rst_sel",    128'(sel2), 128'(0));
      chk("rst_ready",  128'(rdy2), 128'(0));
      chk("rst_flags",  128'({busy2, done2, err2, ld2}), 128'(0));
      @(negedge clk); reset = 1'b1; #1;
      chk("ready_out_of_reset", 128'(rdy2), 128'(1));

      // Good frame
      send(2, gf[0]);
      chk("busy_after_sync", 128'(busy2), 128'(1));
      for (int i = 1; i < 5; i++) send(2, gf[i]);
      chk("no_partial_update", 128'(lut2), 128'(0));
      send(2, gf[5]);
      chk("good_lut",    128'(lut2), 128'(16'h9633));
      chk("good_sel",    128'(sel2), 128'(2'b10));
      chk("good_done",   128'(done2), 128'(1));
      chk("good_loaded", 128'(ld2), 128'(1));
      chk("good_busy",   128'(busy2), 128'(0));
      chk("good_err",    128'(err2), 128'(0));
      idle(1);
      chk("done_one_cycle", 128'(done2), 128'(0));

      // Bad checksum (correct CHK would be FE)
      send(2, 8'hA5); send(2, 8'hFF); send(2, 8'h01);
      send(2, 8'h00); send(2, 8'h00); send(2, 8'h00);
      chk("bad_err",    128'(err2), 128'(1));
      chk("bad_lut",    128'(lut2), 128'(16'h9633));
      chk("bad_done",   128'(done2), 128'(0));
      chk("bad_busy",   128'(busy2), 128'(0));
      idle(2);
      chk("err_sticky", 128'(err2), 128'(1));
      send(2, gf[0]);
      chk("err_clr_on_sync", 128'(err2), 128'(0));
      for (int i = 1; i < 6; i++) send(2, gf[i]);
      chk("recover_done", 128'(done2), 128'(1));

      // Garbage in idle, then the good frame with 3-cycle gaps
      send(2, 8'h12); send(2, 8'h34);
      chk("garbage_busy", 128'(busy2), 128'(0));
      for (int i = 0; i < 6; i++) begin
         send(2, gf[i]);
         if (i < 5) begin
            idle(3);
            chk($sformatf("gap_busy_%0d", i), 128'(busy2), 128'(1));
         end
      end
      chk("gap_lut",  128'(lut2), 128'(16'h9633));
      chk("gap_sel",  128'(sel2), 128'(2'b10));
      chk("gap_done", 128'(done2), 128'(1));

      // Abort with a simultaneous byte; then a different frame commits
      send(2, 8'hA5); send(2, 8'h0F); send(2, 8'h01);
      a2 = 1'b1; v2 = 1'b1; d2 = 8'h55;
      @(posedge clk); #1;
      a2 = 1'b0; v2 = 1'b0;
      chk("abort_busy", 128'(busy2), 128'(0));
      chk("abort_err",  128'(err2), 128'(0));
      chk("abort_done", 128'(done2), 128'(0));
      chk("abort_lut",  128'(lut2), 128'(16'h9633));
      chk("abort_sel",  128'(sel2), 128'(2'b10));
      send(2, 8'hA5); send(2, 8'h0F); send(2, 8'h01);
      send(2, 8'hF0); send(2, 8'h00); send(2, 8'hFE);
      chk("post_abort_lut",  128'(lut2), 128'(16'hF00F));
      chk("post_abort_sel",  128'(sel2), 128'(2'b01));
      chk("post_abort_done", 128'(done2), 128'(1));

      // Asynchronous reset while the first LUT byte is on the bus
      send(2, 8'hA5);
      v2 = 1'b1; d2 = 8'h77;
      #3 reset = 1'b0;
      #1;
      chk("arst_lut",   128'(lut2), 128'(0));
      chk("arst_sel",   128'(sel2), 128'(0));
      chk("arst_ready", 128'(rdy2), 128'(0));
      chk("arst_flags", 128'({busy2, done2, err2, ld2}), 128'(0));
      v2 = 1'b0;
      @(negedge clk); reset = 1'b1;
      for (int i = 0; i < 6; i++) send(2, gf[i]);
      chk("after_arst_lut", 128'(lut2), 128'(16'h9633));
      chk("after_arst_sel", 128'(sel2), 128'(2'b10));

      // NUM_CLB = 1
      send(1, 8'hA5); send(1, 8'hC3); send(1, 8'h01); send(1, 8'hC2);
      chk("n1_lut",  128'(lut1), 128'(8'hC3));
      chk("n1_sel",  128'(sel1), 128'(1));
      chk("n1_done", 128'(done1), 128'(1));

      // NUM_CLB = 16: scoreboard frame, with a sync-valued byte as LUT data
      sum = 8'h00; exp_lut = '0; exp_sel = '0;
      for (int i = 0; i < 16; i++) begin
         lb[i] = (i == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
         cb[i] = 8'($urandom_range(0, 255));
         sum = sum ^ lb[i] ^ cb[i];
         exp_lut[8*i +: 8] = lb[i];
         exp_sel[i] = cb[i][0];
      end
      send(16, 8'hA5);
      for (int i = 0; i < 16; i++) begin send(16, lb[i]); send(16, cb[i]); end
      send(16, sum);
      chk("n16_lut",  lut16, exp_lut);
      chk("n16_sel",  128'(sel16), 128'(exp_sel));
      chk("n16_done", 128'(done16), 128'(1));
      chk("n16_err",  128'(err16), 128'(0));

      // NUM_CLB = 16 with a corrupted checksum leaves the active config alone
      send(16, 8'hA5);
      for (int i = 0; i < 16; i++) begin send(16, ~lb[i]); send(16, cb[i]); end
      send(16, ~sum);
      chk("n16_bad_err", 128'(err16), 128'(1));
      chk("n16_bad_lut", lut16, exp_lut);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
